lcd_i2c_ctrl: RTL
=================

// Module: lcd_i2c_ctrl
// PURPOSE
//  Parametrised HD44780 character-LCD controller driven over I2C through a PCF8574 backpack.
//  Runs the 4-bit power-up init sequence and then accepts command/character writes on a
//  valid/ready port, issuing the cursor positioning itself. Detects slave NACK.
//  Successor to the fixed-message LCD driver; sits beside the sensor pipeline as its display sink.
// PARAMETERS
//  CLK_HZ     100_000_000  system clock frequency
//  I2C_HZ     100_000      SCL frequency; quarter-period tick DIV = CLK_HZ/(4*I2C_HZ)
//  I2C_ADDR   7'h27        PCF8574 7-bit slave address
//  ROWS       2            display rows, 1..4
//  COLS       16           display columns, 1..40
//  BACKLIGHT  1            value driven on PCF8574 P3
//  PWRUP_US   50_000       wait after start before the first init nibble
//  CMD_US     50           settle after every LCD byte except clear/home
//  CLR_US     2_000        settle after 0x01 (clear) or 0x02 (home)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous reset, active-low
//  start_lcd  in   1  level; init starts on a 0->1 transition
//  wr_valid   in   1  write request
//  wr_ready   out  1  write accepted when wr_valid & wr_ready
//  wr_rs      in   1  0 = raw command byte, 1 = character at (wr_row, wr_col)
//  wr_data    in   8  command or character code
//  wr_row     in   2  target row (used only when wr_rs=1)
//  wr_col     in   6  target column (used only when wr_rs=1)
//  init_done  out  1  init sequence completed without NACK
//  busy       out  1  any I2C transaction or settle wait in progress
//  ack_err    out  1  sticky NACK flag
//  range_err  out  1  one-cycle pulse: wr_row>=ROWS or wr_col>=COLS; write dropped
//  scl        out  1  I2C clock (push-pull)
//  sda_oe     out  1  1 = pull SDA low, 0 = release (open-drain)
//  sda_i      in   1  sampled SDA line
// BEHAVIOUR
//  Reset (rst=0, any time, mid-frame included): scl=1, sda_oe=0, wr_ready=0, init_done=0,
//   busy=0, ack_err=0, range_err=0; FSM -> WAIT_START. No STOP is generated on reset.
//  Top FSM: WAIT_START -> PWRUP (PWRUP_US) -> INIT -> IDLE; any NACK -> ERROR.
//  INIT order: nibble 0x3 (wait 4.1 ms), 0x3 (wait 100 us), 0x3, 0x2, then bytes 0x28, 0x0C,
//   0x01, 0x06, each followed by its settle time. init_done=1 on entering IDLE.
//  IDLE: wr_ready=1, busy=0. Accept takes 1 cycle; wr_ready drops the next cycle.
//   wr_rs=0: send wr_data as a command. wr_rs=1: send 0x80|(base[row]+col) then wr_data with RS=1;
//   base = 0x00,0x40,0x14,0x54. Out-of-range: no I2C traffic, range_err pulse, stay IDLE.
//  LCD byte = one I2C frame: START, {I2C_ADDR,0}, then 4 data bytes
//   {hi,BL,1,0,RS},{hi,BL,0,0,RS},{lo,BL,1,0,RS},{lo,BL,0,0,RS}, STOP. Init nibbles send 2 bytes.
//  Bit timing: 4 DIV ticks per bit. SDA changes only while scl=0; sda_i sampled at the tick
//   where scl rises+1 quarter. START: SDA falls with scl=1; STOP: SDA rises with scl=1.
//  ACK slot: sda_oe=0; sda_i=1 -> NACK: finish with STOP, ack_err=1, abandon rest of the
//   LCD operation, go ERROR (init_done=0, wr_ready=0). ERROR exits only on a new start_lcd 0->1,
//   which clears ack_err and restarts from PWRUP.
//  start_lcd 0->1 while in IDLE re-runs init (init_done cleared first); ignored while busy.
//  Settle counters count in microsecond ticks (CLK_HZ/1_000_000 clocks); busy stays 1 through them.
// TESTING
//  Use CLK_HZ=100e6, I2C_HZ=1e6, PWRUP_US=10, slave model ACKing addr 0x27 (and NACK variant).
//  1 Reset, pulse start_lcd -> first frame addr byte 0x4E, data 0x3C,0x38; init_done=1 after 8 ops.
//  2 Write rs=1 row=1 col=3 data=0x41 -> frames carry 0xC3 (RS=0) then 0x41 bytes 0x4D,0x49,0x1D,0x19.
//  3 Write rs=0 data=0x01 -> one frame, busy held >=2000 us, wr_ready returns afterwards.
//  4 Write row=2 with ROWS=2, or col=16 -> range_err one cycle, no SCL activity, wr_ready stays 1.
//  5 Slave NACKs address -> STOP seen, ack_err=1, init_done=0; start_lcd re-toggle clears and re-inits.
//  6 Assert rst mid-byte -> next cycle scl=1, sda_oe=0, all status outputs 0.

Source files
------------

// File: rtl/lcd_i2c_ctrl.sv
// HD44780 character-LCD controller over an I2C PCF8574 backpack: runs the 4-bit
// power-up init, accepts command/character writes with automatic cursor addressing,
// and detects slave NACK (sticky ack_err, ERROR until the next start_lcd rise).
module lcd_i2c_ctrl #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned I2C_HZ    = 100_000,
    parameter logic [6:0]  I2C_ADDR  = 7'h27,
    parameter int unsigned ROWS      = 2,
    parameter int unsigned COLS      = 16,
    parameter logic        BACKLIGHT = 1'b1,
    parameter int unsigned PWRUP_US  = 50_000,
    parameter int unsigned CMD_US    = 50,
    parameter int unsigned CLR_US    = 2_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_lcd,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    input  logic [1:0] wr_row,
    input  logic [5:0] wr_col,
    output logic       init_done,
    output logic       busy,
    output logic       ack_err,
    output logic       range_err,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_i
);
    localparam int unsigned DIV    = CLK_HZ / (4 * I2C_HZ);
    localparam int unsigned US_DIV = CLK_HZ / 1_000_000;

    typedef enum logic [2:0] {
        S_WAIT_START, S_PWRUP, S_IDLE, S_START, S_BITS, S_STOP, S_SETTLE, S_ERROR
    } state_t;
    typedef enum logic [2:0] {LD_NONE, LD_INIT, LD_CMD, LD_ADDR, LD_CHAR} load_t;

    state_t      state_q, state_d;
    load_t       ld;
    logic        start_q, start_rise, tick, us_tick, wait_done, ack_slot, range_bad;
    logic [15:0] tick_cnt, us_cnt;
    logic [31:0] wait_cnt, op_wait, ld_wait;
    logic [1:0]  q;
    logic [3:0]  bit_idx;
    logic [2:0]  byte_idx, last_byte, op_idx, nxt_idx;
    logic [7:0]  shift, op_data, char_data, ld_data;
    logic        op_rs, op_nib, ld_rs, ld_nib, in_init, pend_char, nack;

    // {nibble_only, data} for each step of the power-up sequence
    function automatic logic [8:0] init_op(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2: return 9'h130;
            3'd3:             return 9'h120;
            3'd4:             return 9'h028;
            3'd5:             return 9'h00C;
            3'd6:             return 9'h001;
            default:          return 9'h006;
        endcase
    endfunction

    function automatic logic [7:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'h14;
            default: return 8'h54;
        endcase
    endfunction

    // PCF8574 byte k (1..4) of the current LCD op: odd k carries E=1, even k E=0
    function automatic logic [7:0] data_byte(input logic [2:0] k);
        logic [3:0] n;
        n = (k <= 3'd2) ? op_data[7:4] : op_data[3:0];
        return {n, BACKLIGHT, k[0], 1'b0, op_rs};
    endfunction

    assign start_rise = start_lcd & ~start_q;
    assign tick       = (tick_cnt == 16'(DIV - 1));
    assign us_tick    = (us_cnt == 16'(US_DIV - 1));
    assign wait_done  = (wait_cnt == '0);
    assign ack_slot   = (bit_idx == 4'd8);
    assign last_byte  = op_nib ? 3'd2 : 3'd4;
    assign range_bad  = (32'(wr_row) >= ROWS) || (32'(wr_col) >= COLS);
    assign wr_ready   = (state_q == S_IDLE) && !start_rise;
    assign busy       = state_q inside {S_PWRUP, S_START, S_BITS, S_STOP, S_SETTLE};

    // Next-state logic and selection of the next LCD op to load
    always_comb begin
        state_d = state_q;
        ld      = LD_NONE;
        case (state_q)
            S_WAIT_START: if (start_rise) state_d = S_PWRUP;
            S_PWRUP: if (wait_done) begin state_d = S_START; ld = LD_INIT; end
            S_IDLE: begin
                if (start_rise) state_d = S_PWRUP;
                else if (wr_valid && !wr_rs) begin state_d = S_START; ld = LD_CMD; end
                else if (wr_valid && !range_bad) begin state_d = S_START; ld = LD_ADDR; end
            end
            S_START: if (tick && q == 2'd1) state_d = S_BITS;
            S_BITS: if (tick && q == 2'd3 && ack_slot && (nack || byte_idx == last_byte))
                state_d = S_STOP;
            S_STOP: if (tick && q == 2'd2) state_d = nack ? S_ERROR : S_SETTLE;
            S_SETTLE: if (wait_done) begin
                if (in_init) begin
                    if (op_idx == 3'd7) state_d = S_IDLE;
                    else begin state_d = S_START; ld = LD_INIT; end
                end else if (pend_char) begin state_d = S_START; ld = LD_CHAR; end
                else state_d = S_IDLE;
            end
            S_ERROR: if (start_rise) state_d = S_PWRUP;
            default: state_d = S_WAIT_START;
        endcase
    end

    // Operand and settle time for the op being loaded
    always_comb begin
        nxt_idx = (state_q == S_PWRUP) ? 3'd0 : op_idx + 3'd1;
        ld_data = wr_data;
        ld_rs   = 1'b0;
        ld_nib  = 1'b0;
        case (ld)
            LD_INIT: {ld_nib, ld_data} = init_op(nxt_idx);
            LD_ADDR: ld_data = 8'h80 | (row_base(wr_row) + {2'b00, wr_col});
            LD_CHAR: begin ld_data = char_data; ld_rs = 1'b1; end
            default: ;
        endcase
        if (ld == LD_INIT && nxt_idx == 3'd0)      ld_wait = 32'd4100;
        else if (ld == LD_INIT && nxt_idx == 3'd1) ld_wait = 32'd100;
        else if (!ld_rs && !ld_nib && (ld_data == 8'h01 || ld_data == 8'h02)) ld_wait = CLR_US;
        else                                       ld_wait = CMD_US;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_WAIT_START;
        else      state_q <= state_d;
    end

    // Datapath: op loading, quarter-bit I2C sequencing, settle timing and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q   <= 1'b0;  tick_cnt <= '0;   us_cnt    <= '0;   wait_cnt  <= '0;
            q         <= '0;    bit_idx  <= '0;   byte_idx  <= '0;   shift     <= '0;
            op_data   <= '0;    op_rs    <= 1'b0; op_nib    <= 1'b0; op_wait   <= '0;
            op_idx    <= '0;    in_init  <= 1'b0; pend_char <= 1'b0; char_data <= '0;
            nack      <= 1'b0;  scl      <= 1'b1; sda_oe    <= 1'b0;
            init_done <= 1'b0;  ack_err  <= 1'b0; range_err <= 1'b0;
        end else begin
            start_q   <= start_lcd;
            range_err <= wr_ready && wr_valid && wr_rs && range_bad;

            if (state_q inside {S_START, S_BITS, S_STOP}) tick_cnt <= tick ? '0 : tick_cnt + 16'd1;
            else                                          tick_cnt <= '0;

            if (state_d == S_PWRUP && state_q != S_PWRUP) begin
                wait_cnt  <= PWRUP_US;
                us_cnt    <= '0;
                init_done <= 1'b0;
                ack_err   <= 1'b0;
                in_init   <= 1'b0;
                pend_char <= 1'b0;
            end else if (state_q == S_STOP && state_d == S_SETTLE) begin
                wait_cnt <= op_wait;
                us_cnt   <= '0;
            end else if (!wait_done) begin
                us_cnt <= us_tick ? '0 : us_cnt + 16'd1;
                if (us_tick) wait_cnt <= wait_cnt - 32'd1;
            end

            if (state_q == S_SETTLE && state_d == S_IDLE && in_init) begin
                init_done <= 1'b1;
                in_init   <= 1'b0;
            end
            if (state_q == S_STOP && state_d == S_ERROR) begin
                ack_err   <= 1'b1;
                init_done <= 1'b0;
                in_init   <= 1'b0;
                pend_char <= 1'b0;
            end

            if (ld != LD_NONE) begin
                op_data <= ld_data;
                op_rs   <= ld_rs;
                op_nib  <= ld_nib;
                op_wait <= ld_wait;
                q       <= '0;
                nack    <= 1'b0;
            end
            if (ld == LD_INIT) begin op_idx <= nxt_idx; in_init <= 1'b1; end
            if (ld == LD_ADDR) begin pend_char <= 1'b1; char_data <= wr_data; end
            if (ld == LD_CHAR) pend_char <= 1'b0;

            // Quarter 0: drive SDA (scl low), 1: raise SCL, 2: sample ACK, 3: drop SCL
            if (tick) begin
                case (state_q)
                    S_START: begin
                        if (q == 2'd0) begin
                            sda_oe <= 1'b1;
                            q      <= 2'd1;
                        end else begin
                            scl      <= 1'b0;
                            q        <= 2'd0;
                            shift    <= {I2C_ADDR, 1'b0};
                            byte_idx <= '0;
                            bit_idx  <= '0;
                        end
                    end
                    S_BITS: begin
                        case (q)
                            2'd0: begin sda_oe <= ack_slot ? 1'b0 : ~shift[7]; q <= 2'd1; end
                            2'd1: begin scl <= 1'b1; q <= 2'd2; end
                            2'd2: begin
                                if (ack_slot && sda_i) nack <= 1'b1;
                                q <= 2'd3;
                            end
                            default: begin
                                scl <= 1'b0;
                                q   <= 2'd0;
                                if (!ack_slot) begin
                                    shift   <= shift << 1;
                                    bit_idx <= bit_idx + 4'd1;
                                end else if (!nack && byte_idx != last_byte) begin
                                    byte_idx <= byte_idx + 3'd1;
                                    shift    <= data_byte(byte_idx + 3'd1);
                                    bit_idx  <= '0;
                                end
                            end
                        endcase
                    end
                    S_STOP: begin
                        case (q)
                            2'd0:    begin sda_oe <= 1'b1; q <= 2'd1; end
                            2'd1:    begin scl <= 1'b1; q <= 2'd2; end
                            default: begin sda_oe <= 1'b0; q <= 2'd0; end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
